// File: rtl/irq_rr_arbiter.sv
// irq_rr_arbiter: captures asynchronous request edges into pending bits and
// grants one unmasked pending line at a time, round-robin, as a registered
// one-hot vector with a valid/ack handshake. Requests that arrive on a line
// that is already pending are flagged in a sticky dropped vector.
module irq_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    input  logic [N-1:0] irq_mask,
    input  logic         grant_ack,
    input  logic         drop_clr,
    output logic [N-1:0] grant_onehot,
    output logic         grant_valid,
    output logic [N-1:0] pending,
    output logic [N-1:0] dropped
);

    localparam int unsigned PW = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Input path: two-stage synchronizer plus previous-value stage per line
    logic [N-1:0]  r_s1;
    logic [N-1:0]  r_s2;
    logic [N-1:0]  r_prev;

    // Request bookkeeping
    logic [N-1:0]  r_pending;
    logic [N-1:0]  r_dropped;

    // Grant state
    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic [PW-1:0] r_gidx;
    logic [PW-1:0] w_gidx_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // Combinational helpers
    logic [N-1:0]  w_rise;
    logic [N-1:0]  w_eligible;
    logic          w_found;
    logic [PW-1:0] w_pick_idx;
    logic [N-1:0]  w_pick_oh;
    logic          w_ack;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_pending_nxt;
    logic [N-1:0]  w_dropped_nxt;

    assign w_rise     = r_s2 & ~r_prev;
    assign w_eligible = r_pending & ~irq_mask;
    assign w_clr      = w_ack ? r_grant : '0;

    // Synchronize raw request lines and keep the previous synchronized value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= irq_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Round-robin pick: first eligible line at or above ptr, else the first
    // eligible line below ptr (wrap-around), done as two linear scans
    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        w_pick_oh  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && w_eligible[i] && (i >= 32'(r_ptr))) begin
                w_found    = 1'b1;
                w_pick_idx = PW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && w_eligible[i]) begin
                w_found    = 1'b1;
                w_pick_idx = PW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (w_found && (PW'(i) == w_pick_idx)) begin
                w_pick_oh[i] = 1'b1;
            end
        end
    end

    // Pending/dropped next state: a new edge always wins over an ack clear
    always_comb begin
        w_pending_nxt = (r_pending & ~w_clr) | w_rise;
        w_dropped_nxt = (drop_clr ? '0 : r_dropped) | (w_rise & r_pending & ~w_clr);
    end

    // Pending and dropped registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_dropped <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_dropped <= w_dropped_nxt;
        end
    end

    // Grant FSM next-state and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                if (w_found) begin
                    w_grant_nxt = w_pick_oh;
                    w_valid_nxt = 1'b1;
                    w_gidx_nxt  = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_ack) begin
                    w_ack       = 1'b1;
                    w_ptr_nxt   = (r_gidx == PW'(N - 1)) ? '0 : r_gidx + 1'b1;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant FSM state, grant outputs and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant_onehot = r_grant;
    assign grant_valid  = r_valid;
    assign pending      = r_pending;
    assign dropped      = r_dropped;

endmodule

// File: tb/tb_irq_rr_arbiter.sv
// Testbench for irq_rr_arbiter: directed scenarios with fixed expectations
// plus a randomized run compared against a behavioural model.
module tb_irq_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic [N-1:0] irq_mask = '0;
    logic         grant_ack = 1'b0;
    logic         drop_clr = 1'b0;
    logic [N-1:0] grant_onehot;
    logic         grant_valid;
    logic [N-1:0] pending;
    logic [N-1:0] dropped;

    int n_checks = 0;
    int n_pass = 0;

    irq_rr_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .irq_mask     (irq_mask),
        .grant_ack    (grant_ack),
        .drop_clr     (drop_clr),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .pending      (pending),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    // Behavioural model: samples delayed three edges, grant held as an index
    logic [N-1:0] m_d1 = '0, m_d2 = '0, m_d3 = '0;
    logic [N-1:0] m_pend = '0, m_drop = '0, m_oh = '0;
    int           m_gidx = -1;
    int           m_ptr = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [N-1:0] rise, clr, elig, one;
        int           ng;
        bit           ack;
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_d3 = '0;
            m_pend = '0; m_drop = '0; m_gidx = -1; m_ptr = 0; m_oh = '0;
        end else begin
            one  = 1;
            rise = m_d2 & ~m_d3;
            ack  = (m_gidx >= 0) && grant_ack;
            clr  = ack ? (one << m_gidx) : '0;
            ng   = m_gidx;
            if (m_gidx < 0) begin
                elig = m_pend & ~irq_mask;
                for (int k = 0; k < N; k++) begin
                    if (ng < 0 && elig[(m_ptr + k) % N]) ng = (m_ptr + k) % N;
                end
            end else if (ack) begin
                m_ptr = (m_gidx + 1) % N;
                ng = -1;
            end
            m_drop = (drop_clr ? '0 : m_drop) | (rise & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | rise;
            m_gidx = ng;
            m_oh   = (ng < 0) ? '0 : (one << ng);
            m_d3 = m_d2; m_d2 = m_d1; m_d1 = irq_in;
        end
    end

    // Grant vector must be zero when invalid and exactly one-hot when valid
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((grant_valid && $countones(grant_onehot) != 1) || (!grant_valid && grant_onehot != '0))
                $display("FAIL onehot_invariant: grant_onehot=%b grant_valid=%b", grant_onehot, grant_valid);
            else n_pass++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; irq_in = '0; irq_mask = '0; grant_ack = 1'b0; drop_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Lower all lines long enough to be seen low, then drive the new pattern
    task automatic drive_edge(input logic [N-1:0] v);
        irq_in = '0;
        repeat (3) @(negedge clk);
        irq_in = v;
    endtask

    task automatic wait_grant(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (grant_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic ack_grant();
        grant_ack = 1'b1;
        @(negedge clk);
        grant_ack = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        int bad;
        do_reset();
        n_checks++; if ({grant_onehot, grant_valid, pending, dropped} !== '0) $display("FAIL reset_state: got %b/%b/%b/%b want all 0", grant_onehot, grant_valid, pending, dropped); else n_pass++;
        drive_edge(4'b0101);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0001) $display("FAIL reset_pre_grant: got %b valid %b want 0001", grant_onehot, grant_valid); else n_pass++;
        n_checks++; if (pending !== 4'b0101) $display("FAIL reset_pre_pending: got %b want 0101", pending); else n_pass++;
        rst_n = 1'b0;
        irq_in = '0;
        #1;
        n_checks++; if ({grant_onehot, grant_valid, pending, dropped} !== '0) $display("FAIL reset_async: got %b/%b/%b/%b want all 0", grant_onehot, grant_valid, pending, dropped); else n_pass++;
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant_valid || pending != '0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL reset_quiet: got %0d busy cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        @(negedge clk) irq_in = 4'b0001;
        repeat (2) @(negedge clk);
        n_checks++; if (pending !== 4'b0000) $display("FAIL single_early_pending: got %b want 0000", pending); else n_pass++;
        @(negedge clk);
        n_checks++; if (pending !== 4'b0001 || grant_valid !== 1'b0) $display("FAIL single_pending: got %b valid %b want 0001 valid 0", pending, grant_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (grant_valid !== 1'b1 || grant_onehot !== 4'b0001) $display("FAIL single_grant: got %b valid %b want 0001 valid 1", grant_onehot, grant_valid); else n_pass++;
        ack_grant();
        n_checks++; if (grant_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL single_after_ack: got valid %b pending %b want 0 0000", grant_valid, pending); else n_pass++;
        // pointer now 1: with lines 0 and 1 both requesting, line 1 goes first
        drive_edge(4'b0011);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0010) $display("FAIL single_ptr1: got %b want 0010", grant_onehot); else n_pass++;
        ack_grant();
        wait_grant(3, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0001) $display("FAIL single_ptr1_next: got %b want 0001", grant_onehot); else n_pass++;
        ack_grant();
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        @(negedge clk) irq_in = 4'b1010;
        wait_grant(8, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0010 || pending !== 4'b1010) $display("FAIL simul_first: got %b pending %b want 0010 1010", grant_onehot, pending); else n_pass++;
        ack_grant();
        n_checks++; if (grant_valid !== 1'b0 || pending !== 4'b1000) $display("FAIL simul_gap: got valid %b pending %b want 0 1000", grant_valid, pending); else n_pass++;
        @(negedge clk);
        n_checks++; if (grant_valid !== 1'b1 || grant_onehot !== 4'b1000) $display("FAIL simul_second: got %b valid %b want 1000 1", grant_onehot, grant_valid); else n_pass++;
        ack_grant();
        n_checks++; if (grant_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL simul_done: got valid %b pending %b want 0 0000", grant_valid, pending); else n_pass++;
        // pointer back to 0: line 0 beats line 3
        drive_edge(4'b1001);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0001) $display("FAIL simul_ptr0: got %b want 0001", grant_onehot); else n_pass++;
        ack_grant();
        wait_grant(3, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b1000) $display("FAIL simul_ptr0_next: got %b want 1000", grant_onehot); else n_pass++;
        ack_grant();
    endtask

    task automatic test_rr_wrap();
        bit ok;
        do_reset();
        drive_edge(4'b0001);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0001) $display("FAIL wrap_line0: got %b want 0001", grant_onehot); else n_pass++;
        ack_grant();
        drive_edge(4'b0101);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0100) $display("FAIL wrap_ptr1_first: got %b want 0100", grant_onehot); else n_pass++;
        ack_grant();
        n_checks++; if (grant_valid !== 1'b0) $display("FAIL wrap_throughput: got valid %b want 0", grant_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (grant_onehot !== 4'b0001 || grant_valid !== 1'b1) $display("FAIL wrap_ptr1_second: got %b want 0001", grant_onehot); else n_pass++;
        ack_grant();
        drive_edge(4'b0100);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0100) $display("FAIL wrap_line2: got %b want 0100", grant_onehot); else n_pass++;
        ack_grant();
        drive_edge(4'b1001);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b1000) $display("FAIL wrap_ptr3_first: got %b want 1000", grant_onehot); else n_pass++;
        ack_grant();
        @(negedge clk);
        n_checks++; if (grant_onehot !== 4'b0001 || grant_valid !== 1'b1) $display("FAIL wrap_ptr3_second: got %b want 0001", grant_onehot); else n_pass++;
        ack_grant();
    endtask

    task automatic test_mask();
        bit ok;
        int seen;
        do_reset();
        irq_mask = 4'b0001;
        drive_edge(4'b0001);
        repeat (3) @(negedge clk);
        n_checks++; if (pending !== 4'b0001) $display("FAIL mask_pending: got %b want 0001", pending); else n_pass++;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant_valid) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL mask_blocks: got %0d grant cycles want 0", seen); else n_pass++;
        irq_mask = 4'b0000;
        @(negedge clk);
        n_checks++; if (grant_valid !== 1'b1 || grant_onehot !== 4'b0001) $display("FAIL mask_release: got %b valid %b want 0001 1", grant_onehot, grant_valid); else n_pass++;
        irq_mask = 4'b0001;
        repeat (3) @(negedge clk);
        n_checks++; if (grant_valid !== 1'b1 || grant_onehot !== 4'b0001) $display("FAIL mask_hold: got %b valid %b want 0001 1", grant_onehot, grant_valid); else n_pass++;
        ack_grant();
        irq_mask = 4'b0000;
        wait_grant(4, ok);
        n_checks++; if (ok !== 1'b0) $display("FAIL mask_no_regrant: got grant %b want none", grant_onehot); else n_pass++;
    endtask

    task automatic test_drop_collision();
        bit ok;
        do_reset();
        irq_mask = 4'b0100;
        drive_edge(4'b0100);
        repeat (4) @(negedge clk);
        n_checks++; if (pending !== 4'b0100 || dropped !== 4'b0000 || grant_valid !== 1'b0) $display("FAIL drop_setup: got pending %b dropped %b valid %b want 0100 0000 0", pending, dropped, grant_valid); else n_pass++;
        drive_edge(4'b0100);
        repeat (3) @(negedge clk);
        n_checks++; if (dropped !== 4'b0100 || pending !== 4'b0100) $display("FAIL drop_set: got dropped %b pending %b want 0100 0100", dropped, pending); else n_pass++;
        drop_clr = 1'b1;
        @(negedge clk) drop_clr = 1'b0;
        n_checks++; if (dropped !== 4'b0000 || pending !== 4'b0100) $display("FAIL drop_clear: got dropped %b pending %b want 0000 0100", dropped, pending); else n_pass++;
        drive_edge(4'b0010);
        wait_grant(10, ok);
        n_checks++; if (!ok || grant_onehot !== 4'b0010) $display("FAIL coll_grant: got %b want 0010", grant_onehot); else n_pass++;
        drive_edge(4'b0010);
        @(negedge clk);
        @(negedge clk) grant_ack = 1'b1;
        @(negedge clk) grant_ack = 1'b0;
        n_checks++; if (grant_valid !== 1'b0 || pending !== 4'b0110 || dropped !== 4'b0000) $display("FAIL coll_ack: got valid %b pending %b dropped %b want 0 0110 0000", grant_valid, pending, dropped); else n_pass++;
        @(negedge clk);
        n_checks++; if (grant_valid !== 1'b1 || grant_onehot !== 4'b0010) $display("FAIL coll_regrant: got %b valid %b want 0010 1", grant_onehot, grant_valid); else n_pass++;
        ack_grant();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant_onehot !== m_oh || grant_valid !== (m_gidx >= 0) || pending !== m_pend || dropped !== m_drop) begin
                if (errs < 10) $display("FAIL random_cycle%0d: got g=%b v=%b p=%b d=%b want g=%b v=%b p=%b d=%b", c, grant_onehot, grant_valid, pending, dropped, m_oh, (m_gidx >= 0), m_pend, m_drop);
                errs++;
            end else n_pass++;
            v = irq_in;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
            irq_in = v;
            if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom);
            grant_ack = ($urandom_range(0, 2) == 0);
            drop_clr  = ($urandom_range(0, 9) == 0);
        end
        grant_ack = 1'b0;
        drop_clr  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_rr_wrap();
        test_mask();
        test_drop_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_rr_arbiter.md
Name: irq_rr_arbiter

Overview:
Captures up to N asynchronous interrupt/request lines and holds them as pending bits. It arbitrates among them round-robin and presents exactly one winning line as a one-hot vector with a valid/ack handshake. It sits directly upstream of the 4-to-2 priority encoder in the risc32i core: grant_onehot drives the encoder's 4-bit input, so the encoder never sees more than one hot bit. A dropped-request flag records requests lost while already pending.

Parameters:
N, 4, number of request lines; must be ≥2; the encoder-facing configuration is N=4.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
irq_in  in  N  raw request lines, asynchronous; a rising edge raises a request.
irq_mask  in  N  1 = line masked; stays pending but is not granted.
grant_ack  in  1  consumer accepts the current grant.
drop_clr  in  1  clears the dropped flags.
grant_onehot  out  N  one-hot winning line; all zero when grant_valid=0.
grant_valid  out  1  grant_onehot holds a valid grant.
pending  out  N  pending request bits.
dropped  out  N  sticky flag: an edge arrived on a line that was already pending.

Behaviour:
- Reset (rst_n=0, async): sync flops, previous-value flops, pending, dropped, grant_onehot, grant_valid and ptr all go to 0; FSM goes to IDLE. Takes effect immediately, including mid-GRANT.
- After reset release, a line already high produces one rising edge. This is intended.
- Input path, per line: 2-flop synchronizer (s1, s2) plus a prev flop. rise[i] = s2 & ~prev.
- Latency: irq_in high before edge E0 → rise at E0+1 → pending[i]=1 after E0+2 → if FSM idle and line unmasked, grant_valid=1 after E0+3.
- Pending update per line, each cycle:
  - set if rise[i];
  - clear if acked line = i;
  - set wins over clear in the same cycle, so no request is lost.
- dropped[i] sets if rise[i] & pending[i] and the line is not being cleared this cycle. drop_clr clears all bits; a set in the same cycle wins.
- ptr: log2(N)-bit round-robin pointer, reset 0.
- FSM IDLE:
  - eligible = pending & ~irq_mask.
  - If eligible ≠ 0: choose the first set bit scanning from index ptr upward, wrapping at N−1→0.
  - Register grant_onehot = that bit and grant_valid = 1; go to GRANT.
  - Else stay; outputs 0.
- FSM GRANT:
  - grant_onehot and grant_valid stay stable until grant_ack=1.
  - Mask changes or new requests do not alter or revoke the grant.
  - On grant_ack: clear that line's pending bit, set ptr = (granted index+1) mod N, set grant_onehot=0 and grant_valid=0, return to IDLE.
  - Next grant appears no earlier than one cycle later, so maximum throughput is one grant per 2 cycles.
- grant_ack while grant_valid=0 is ignored. grant_ack held high is consumed once per grant.
- grant_onehot is always 0 or exactly one-hot; the bench asserts this every cycle.
- drop_clr does not affect pending or the grant.

Test Plan:
1. Reset mid-operation: pending=0101 and grant_valid=1, then pulse rst_n=0 between clock edges → all outputs 0 before the next edge; after release with irq_in=0, no grant for 10 cycles.
2. Single request, N=4, mask=0000: irq_in 0000→0001 before edge E0 → pending=0001 after E0+2, grant_onehot=0001 and grant_valid=1 after E0+3. Assert grant_ack for one cycle → next cycle grant_valid=0, pending=0000, ptr=1.
3. Simultaneous requests: from reset, irq_in 0000→1010 in one step → grant 0010 first. Ack → one idle cycle, then grant 1000. Ack → pending=0000, ptr=0.
4. Round-robin wrap: line 0 granted and acked (ptr=1), with pending=0101 → next grant 0100, then 0001. Repeat with ptr=3 and pending=1001 → grant 1000 then 0001.
5. Masking: irq_mask=0001, irq_in rises on line 0 → pending=0001, grant_valid stays 0 for 8 cycles. Set irq_mask=0000 → grant_onehot=0001 one cycle later. Masking line 0 during GRANT does not drop the grant.
6. Drop and collision: with pending[2]=1 and not granted, a second rise on line 2 → dropped=0100. Assert drop_clr → dropped=0000. A new rise on line 1 arriving in its grant_ack cycle → pending[1] stays 1, dropped[1]=0, and a fresh grant 0010 follows.
